// File: rtl/sys_ctrl_pkg.sv
// Shared system-control definitions: UART command opcodes,
// ALU operand register addresses and the receive FSM encoding.
package sys_ctrl_pkg;

    localparam logic [7:0] OP_WR  = 8'hAA;
    localparam logic [7:0] OP_RD  = 8'hBB;
    localparam logic [7:0] OP_ALU = 8'hCC;
    localparam logic [7:0] OP_FUN = 8'hDD;

    localparam int unsigned OPA_ADDR  = 0;
    localparam int unsigned OPB_ADDR  = 1;
    localparam int unsigned FUN_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_OPA     = 3'd4,
        ST_OPB     = 3'd5,
        ST_FUN     = 3'd6
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_rx_if.sv
// Byte stream in from the UART receiver, register-file and
// ALU command strobes out to the rest of the system.
interface ctrl_rx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    import sys_ctrl_pkg::*;

    logic [DATA_WIDTH-1:0] RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] WrData;
    logic                  ALU_EN;
    logic [FUN_WIDTH-1:0]  ALU_FUN;
    logic                  CLKG_EN;

    modport master (
        output RX_P_DATA, RX_D_VLD,
        input  WrEn, RdEn, Address, WrData,
        input  ALU_EN, ALU_FUN, CLKG_EN
    );

    modport slave (
        input  RX_P_DATA, RX_D_VLD,
        output WrEn, RdEn, Address, WrData,
        output ALU_EN, ALU_FUN, CLKG_EN
    );

endinterface

// File: rtl/ctrl_rx.sv
// Command decoder: turns received UART bytes into one-cycle
// register-file write/read and ALU start strobes.
module ctrl_rx
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic CLK,
    input  logic RST,
    ctrl_rx_if.slave bus
);

    localparam logic [DATA_WIDTH-1:0] B_WR  = DATA_WIDTH'(OP_WR);
    localparam logic [DATA_WIDTH-1:0] B_RD  = DATA_WIDTH'(OP_RD);
    localparam logic [DATA_WIDTH-1:0] B_ALU = DATA_WIDTH'(OP_ALU);
    localparam logic [DATA_WIDTH-1:0] B_FUN = DATA_WIDTH'(OP_FUN);

    ctrl_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  alu_en_q, alu_en_d;
    logic                  clkg_en_q, clkg_en_d;
    logic [DATA_WIDTH-1:0] rx_byte;

    assign rx_byte = bus.RX_P_DATA;

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        alu_fun_d = alu_fun_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        alu_en_d  = 1'b0;
        if (bus.RX_D_VLD) begin
            unique case (state_q)
                ST_IDLE: begin
                    unique case (rx_byte)
                        B_WR:    state_d = ST_WR_ADDR;
                        B_RD:    state_d = ST_RD_ADDR;
                        B_ALU:   state_d = ST_OPA;
                        B_FUN:   state_d = ST_FUN;
                        default: state_d = ST_IDLE;
                    endcase
                end
                // Held aside so Address only moves with a strobe.
                ST_WR_ADDR: begin
                    wr_addr_d = rx_byte[ADDR_WIDTH-1:0];
                    state_d   = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    addr_d    = wr_addr_q;
                    wr_data_d = rx_byte;
                    wr_en_d   = 1'b1;
                    state_d   = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    addr_d  = rx_byte[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_OPA: begin
                    addr_d    = ADDR_WIDTH'(OPA_ADDR);
                    wr_data_d = rx_byte;
                    wr_en_d   = 1'b1;
                    state_d   = ST_OPB;
                end
                ST_OPB: begin
                    addr_d    = ADDR_WIDTH'(OPB_ADDR);
                    wr_data_d = rx_byte;
                    wr_en_d   = 1'b1;
                    state_d   = ST_FUN;
                end
                ST_FUN: begin
                    alu_fun_d = rx_byte[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        clkg_en_d = alu_en_d ||
                    state_d == ST_OPA ||
                    state_d == ST_OPB ||
                    state_d == ST_FUN;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            alu_fun_q <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            alu_en_q  <= 1'b0;
            clkg_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            alu_fun_q <= alu_fun_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            alu_en_q  <= alu_en_d;
            clkg_en_q <= clkg_en_d;
        end
    end

    assign bus.WrEn    = wr_en_q;
    assign bus.RdEn    = rd_en_q;
    assign bus.Address = addr_q;
    assign bus.WrData  = wr_data_q;
    assign bus.ALU_EN  = alu_en_q;
    assign bus.ALU_FUN = alu_fun_q;
    assign bus.CLKG_EN = clkg_en_q;

endmodule
